// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divider_seq
//  Description : Sequential 16-by-8 unsigned restoring divider. Produces one
//                quotient bit per cycle (16 cycles per division) with
//                valid/ready handshakes on the input and result sides.
//                Serves as the reference check for 8-bit multiplier products
//                in the approximate-computing experiment harness.
//
//  Ports       : clk        in   1   clock, all state updates on rising edge
//                rst        in   1   synchronous active-high reset
//                in_valid   in   1   A/B valid
//                in_ready   out  1   divider can accept (IDLE only)
//                A          in  16   dividend, unsigned
//                B          in   8   divisor, unsigned
//                out_valid  out  1   Q/R/DZ valid
//                out_ready  in   1   consumer accepts result
//                Q          out 16   quotient, floor(A/B)
//                R          out  8   remainder, A mod B
//                DZ         out  1   divisor was zero
//
//  Build option: DIVIDER_SEQ_ZERO_SHORTCUT_EN
//                Defined   -> B == 0 jumps IDLE -> DONE at acceptance with
//                             the divide-by-zero result preloaded.
//                Undefined -> B == 0 runs the normal 16 steps; the restoring
//                             algorithm yields the same Q/R/DZ naturally.
//
//  Revision    : 1.0  initial release
// ============================================================================
module divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Q,
    output logic [7:0]  R,
    output logic        DZ
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [3:0] c_LAST_STEP_CNT = 4'd15;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [15:0] r_dvd;     // dividend shift register, becomes the quotient
    logic [7:0]  r_dsr;     // captured divisor
    logic [7:0]  r_rem;     // partial remainder
    logic [3:0]  r_cnt;     // remaining steps after the current one
    logic        r_dz;      // divisor was zero

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]  w_state_next;
    logic [8:0]  w_trial;
    logic        w_ge;
    logic [7:0]  w_diff;
    logic [7:0]  w_rem_next;
    logic        w_zero_b;
    logic        w_shortcut;
    logic        w_last;

    assign w_zero_b = (B == 8'd0);
    assign w_last   = (r_cnt == 4'd0);

`ifdef DIVIDER_SEQ_ZERO_SHORTCUT_EN
    assign w_shortcut = w_zero_b;
`else
    assign w_shortcut = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // One restoring step. The trial value brings down the next dividend bit.
    // The subtraction is done on 8 bits only: whenever the trial is >= the
    // divisor the true difference is below the divisor (or, for a zero
    // divisor, equals the trial), so its low 8 bits are exact.
    // ------------------------------------------------------------------------
    assign w_trial    = {r_rem, r_dvd[15]};
    assign w_ge       = (w_trial >= {1'b0, r_dsr});
    assign w_diff     = w_trial[7:0] - r_dsr;
    assign w_rem_next = w_ge ? w_diff : w_trial[7:0];

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = w_shortcut ? c_ST_DONE : c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (w_last) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath. Registers only change on acceptance and during BUSY, so the
    // result is held stable throughout DONE regardless of the inputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd <= 16'd0;
            r_dsr <= 8'd0;
            r_rem <= 8'd0;
            r_cnt <= 4'd0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_dsr <= B;
                        r_cnt <= c_LAST_STEP_CNT;
                        r_dz  <= w_zero_b;
                        if (w_shortcut) begin
                            // Same values 16 steps of division by zero produce:
                            // every quotient bit set, A[7:0] left in remainder.
                            r_dvd <= 16'hFFFF;
                            r_rem <= A[7:0];
                        end else begin
                            r_dvd <= A;
                            r_rem <= 8'd0;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_dvd <= {r_dvd[14:0], w_ge};
                    r_rem <= w_rem_next;
                    if (!w_last) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    // DONE and unused encodings hold the datapath
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Result outputs
    // ------------------------------------------------------------------------
    assign Q  = r_dvd;
    assign R  = r_rem;
    assign DZ = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_seq
//  Description : Self-checking bench for divider_seq. Directed vectors with
//                hand-computed quotients/remainders, result hold under
//                back-pressure, mid-operation reset, and a randomised sweep
//                checked against the division identity Q*B+R == A, R < B.
//                Honours DIVIDER_SEQ_ZERO_SHORTCUT_EN for divide-by-zero
//                latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divider_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        DZ;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_res    = 0;

    divider_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .DZ        (DZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor: counts accepted inputs and delivered results
    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)   n_acc <= n_acc + 1;
            if (out_valid && out_ready) n_res <= n_res + 1;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one division; lat = edges after the accepting edge until out_valid
    // is observed. stall = cycles out_ready is held low once out_valid is up.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int stall,
                         input bit verbose, output logic [15:0] q, output logic [7:0] r,
                         output logic dz, output int lat);
        q = 16'd0; r = 8'd0; dz = 1'b0;
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        if (verbose) check("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        A = 16'($urandom); B = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            check("timeout_out_valid", 32'd0, 32'd1);
            return;
        end
        q = Q; r = R; dz = DZ;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            A = 16'($urandom); B = 8'($urandom);
            tick();
            if (verbose) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_ready", {31'd0, in_ready}, 32'd0);
                check("hold_q", {16'd0, Q}, {16'd0, q});
                check("hold_r", {24'd0, R}, {24'd0, r});
                check("hold_dz", {31'd0, DZ}, {31'd0, dz});
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (verbose) begin
            check("post_valid", {31'd0, out_valid}, 32'd0);
            check("post_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [7:0] b,
                            input int stall, input logic [15:0] eq, input logic [7:0] er,
                            input logic edz, input int elat);
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          lat;
        do_op(a, b, stall, 1'b1, q, r, dz, lat);
        check({tag, "_q"},   {16'd0, q},  {16'd0, eq});
        check({tag, "_r"},   {24'd0, r},  {24'd0, er});
        check({tag, "_dz"},  {31'd0, dz}, {31'd0, edz});
        check({tag, "_lat"}, lat,         elat);
    endtask

    int          zero_lat;
    int          acc0;
    int          res0;
    logic [15:0] sq;
    logic [7:0]  sr;
    logic        sdz;
    int          slat;
    logic [15:0] sa;
    logic [7:0]  sb;

    initial begin
`ifdef DIVIDER_SEQ_ZERO_SHORTCUT_EN
        // Result is up right after the accepting edge: handshake possible at N+1
        zero_lat = 0;
`else
        zero_lat = 16;
`endif
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = 16'd0; B = 8'd0;
        tick();
        tick();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q",         {16'd0, Q},         32'd0);
        check("rst_r",         {24'd0, R},         32'd0);
        check("rst_dz",        {31'd0, DZ},        32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors (hand-computed)
        directed("d35505_201", 16'd35505, 8'd201, 0, 16'd176,   8'd129, 1'b0, 16);
        directed("d65025_255", 16'd65025, 8'd255, 0, 16'd255,   8'd0,   1'b0, 16);
        directed("d0_7",       16'd0,     8'd7,   0, 16'd0,     8'd0,   1'b0, 16);
        directed("d65535_1",   16'd65535, 8'd1,   0, 16'd65535, 8'd0,   1'b0, 16);
        directed("d65535_255", 16'd65535, 8'd255, 0, 16'd257,   8'd0,   1'b0, 16);
        directed("d65535_2",   16'd65535, 8'd2,   0, 16'd32767, 8'd1,   1'b0, 16);
        directed("d100_200",   16'd100,   8'd200, 0, 16'd0,     8'd100, 1'b0, 16);
        directed("d1000_0",    16'd1000,  8'd0,   0, 16'hFFFF,  8'hE8,  1'b1, zero_lat);
        // Back-pressure: 5 stalled cycles with in_valid/A/B toggling
        directed("d1234_10",   16'd1234,  8'd10,  5, 16'd123,   8'd4,   1'b0, 16);

        // Reset in the middle of an operation (just before step 8)
        A = 16'd1234; B = 8'd10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_q",         {16'd0, Q},         32'd0);
        check("abort_r",         {24'd0, R},         32'd0);
        directed("d300_7", 16'd300, 8'd7, 0, 16'd42, 8'd6, 1'b0, 16);

        // Randomised sweep with result-side stalls
        acc0 = n_acc;
        res0 = n_res;
        for (int k = 0; k < 300; k++) begin
            sa = 16'($urandom);
            sb = 8'($urandom_range(1, 255));
            do_op(sa, sb, $urandom_range(0, 3), 1'b0, sq, sr, sdz, slat);
            check("sweep_identity", int'(sq) * int'(sb) + int'(sr), {16'd0, sa});
            check("sweep_rem_lt_b", {31'd0, (sr < sb)}, 32'd1);
        end
        check("sweep_accepts", n_acc - acc0, 32'd300);
        check("sweep_results", n_res - res0, n_acc - acc0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
